// File: rtl/mem_writeback.sv
// Memory/writeback stage of the Riscv151 pipeline: drives the data cache in the execute
// cycle, then extends load data and selects the register-file write value one cycle later.
module mem_writeback #(
    parameter logic [31:0] CSR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        kill,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    input  logic        ex_mem_we,
    input  logic        ex_mem_rr,
    input  logic        ex_csr_we,
    input  logic [1:0]  ex_wb_sel,
    input  logic [31:0] ex_pc,
    output logic [31:0] dcache_addr,
    output logic [3:0]  dcache_we,
    output logic        dcache_re,
    output logic [31:0] dcache_din,
    input  logic [31:0] dcache_dout,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] csr,
    output logic        misaligned
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    typedef struct packed {
        logic        valid;
        logic        reg_we;
        logic        load;
        logic        csr_we;
        logic [1:0]  wb_sel;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        mis;
    } w_stage_t;

    w_stage_t    w_q, w_d;
    logic [31:0] csr_q, csr_d;

    logic        misalign_ex;
    logic        qual_ex;
    logic [3:0]  lane_mask;
    logic [31:0] load_shifted;
    logic [31:0] load_data;

    // Execute cycle: address, lane enables and replicated store data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        misalign_ex = 1'b0;
        lane_mask   = 4'b1111;
        dcache_din  = ex_store_data;
        unique case (ex_funct3[1:0])
            SZ_BYTE: begin
                lane_mask  = 4'b0001 << ex_alu_result[1:0];
                dcache_din = {4{ex_store_data[7:0]}};
            end
            SZ_HALF: begin
                misalign_ex = ex_alu_result[0];
                lane_mask   = 4'b0011 << ex_alu_result[1:0];
                dcache_din  = {2{ex_store_data[15:0]}};
            end
            SZ_WORD: misalign_ex = (ex_alu_result[1:0] != 2'b00);
            default: ;
        endcase
        misalign_ex = misalign_ex & (ex_mem_we | ex_mem_rr);
        qual_ex     = ~kill & ~misalign_ex;
        dcache_addr = {ex_alu_result[31:2], 2'b00};
        dcache_re   = ex_mem_rr & qual_ex;
        dcache_we   = (ex_mem_we & qual_ex) ? lane_mask : 4'b0000;
    end

    // E->W register contents and csr commit; a stall holds everything.
    always_comb begin
        w_d   = w_q;
        csr_d = csr_q;
        if (!stall) begin
            w_d.valid   = ~kill;
            w_d.reg_we  = ex_reg_we & ~kill & ~misalign_ex;
            w_d.load    = ex_mem_rr & ~kill;
            w_d.csr_we  = ex_csr_we & ~kill;
            w_d.wb_sel  = ex_wb_sel;
            w_d.rd      = ex_rd;
            w_d.funct3  = ex_funct3;
            w_d.addr_lo = ex_alu_result[1:0];
            w_d.alu     = ex_alu_result;
            w_d.pc4     = ex_pc + 32'd4;
            w_d.mis     = misalign_ex & ~kill;
            if (w_q.csr_we && w_q.valid) begin
                csr_d = w_q.alu;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q   <= '0;
            csr_q <= CSR_RESET;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            w_q   <= w_d;
            csr_q <= csr_d;
        end
    end

    // Writeback cycle: align the addressed lane down, then extend by width/signedness.
    always_comb begin
        load_shifted = dcache_dout >> {w_q.addr_lo, 3'b000};
        unique case (w_q.funct3)
            3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_data = {24'h0, load_shifted[7:0]};
            3'b101:  load_data = {16'h0, load_shifted[15:0]};
            default: load_data = dcache_dout;
        endcase
        // A squashed load never forwards stale cache data.
        if (!w_q.load) begin
            load_data = 32'h0;
        end
    end

    always_comb begin
        unique case (w_q.wb_sel)
            WB_LOAD: wb_data = load_data;
            WB_PC4:  wb_data = w_q.pc4;
            default: wb_data = w_q.alu;
        endcase
        wb_we      = w_q.reg_we & w_q.valid & (w_q.rd != 5'd0);
        wb_rd      = w_q.rd;
        misaligned = w_q.mis;
        csr        = csr_q;
    end

endmodule

// File: tb/tb_mem_writeback.sv
// Directed self-checking bench for mem_writeback: store lanes, load extension,
// misalignment, kill/x0, stall hold and asynchronous reset.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        kill;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        ex_mem_we;
    logic        ex_mem_rr;
    logic        ex_csr_we;
    logic [1:0]  ex_wb_sel;
    logic [31:0] ex_pc;
    logic [31:0] dcache_addr;
    logic [3:0]  dcache_we;
    logic        dcache_re;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] csr;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_writeback #(.CSR_RESET(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .kill(kill),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .ex_mem_we(ex_mem_we), .ex_mem_rr(ex_mem_rr), .ex_csr_we(ex_csr_we),
        .ex_wb_sel(ex_wb_sel), .ex_pc(ex_pc),
        .dcache_addr(dcache_addr), .dcache_we(dcache_we), .dcache_re(dcache_re),
        .dcache_din(dcache_din), .dcache_dout(dcache_dout),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .csr(csr),
        .misaligned(misaligned)
    );

    task automatic set_ex(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                          input logic [4:0] rd, input logic reg_we, input logic mem_we,
                          input logic mem_rr, input logic csr_we, input logic [1:0] wb_sel,
                          input logic [31:0] pc);
        ex_alu_result = alu;  ex_store_data = sd;  ex_funct3 = f3;  ex_rd = rd;
        ex_reg_we = reg_we;   ex_mem_we = mem_we;  ex_mem_rr = mem_rr;
        ex_csr_we = csr_we;   ex_wb_sel = wb_sel;  ex_pc = pc;
    endtask

    task automatic bubble();
        set_ex(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b expected 0", wb_we); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d expected 0", wb_rd); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
        checks++; if (csr !== 32'h0) begin errors++; $display("FAIL reset_csr: got %h expected 0", csr); end
    endtask

    task automatic test_store();
        logic [2:0]  f3  [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] adr [3] = '{32'h1003, 32'h1002, 32'h1004};
        logic [31:0] sd  [3] = '{32'h0000_00A5, 32'h0000_1234, 32'hDEAD_BEEF};
        logic [3:0]  ewe [3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] edi [3] = '{32'hA5A5_A5A5, 32'h1234_1234, 32'hDEAD_BEEF};
        logic [31:0] ead [3] = '{32'h1000, 32'h1000, 32'h1004};
        for (int i = 0; i < 3; i++) begin
            set_ex(adr[i], sd[i], f3[i], 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
            #1;
            checks++; if (dcache_we !== ewe[i]) begin errors++; $display("FAIL store_we[%0d]: got %b expected %b", i, dcache_we, ewe[i]); end
            checks++; if (dcache_din !== edi[i]) begin errors++; $display("FAIL store_din[%0d]: got %h expected %h", i, dcache_din, edi[i]); end
            checks++; if (dcache_addr !== ead[i]) begin errors++; $display("FAIL store_addr[%0d]: got %h expected %h", i, dcache_addr, ead[i]); end
        end
        bubble();
        tick();
    endtask

    task automatic test_load();
        logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b000};
        logic [1:0]  off [6] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
        logic [31:0] exp [6] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0,
                                 32'h80F0_7F01, 32'h0000_7F01, 32'h0000_007F};
        for (int i = 0; i < 6; i++) begin
            set_ex(32'h3000 | {30'h0, off[i]}, 32'h0, f3[i], 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0);
            dcache_dout = 32'h0;
            #1;
            checks++; if (dcache_re !== 1'b1) begin errors++; $display("FAIL load_re[%0d]: got %b expected 1", i, dcache_re); end
            tick();
            bubble();
            dcache_dout = 32'h80F0_7F01;
            #1;
            checks++; if (wb_data !== exp[i]) begin errors++; $display("FAIL load_data[%0d]: got %h expected %h", i, wb_data, exp[i]); end
            checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5) begin errors++; $display("FAIL load_wb[%0d]: got we=%b rd=%0d expected we=1 rd=5", i, wb_we, wb_rd); end
        end
        tick();
    endtask

    task automatic test_misaligned();
        set_ex(32'h2002, 32'h0, 3'b010, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0);
        #1;
        checks++; if (dcache_re !== 1'b0) begin errors++; $display("FAIL mis_lw_re: got %b expected 0", dcache_re); end
        tick();
        set_ex(32'h2001, 32'h0000_1234, 3'b001, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        #1;
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_lw_flag: got %b expected 1", misaligned); end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL mis_lw_we: got %b expected 0", wb_we); end
        checks++; if (dcache_we !== 4'b0000) begin errors++; $display("FAIL mis_sh_we: got %b expected 0000", dcache_we); end
        tick();
        bubble();
        #1;
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sh_flag: got %b expected 1", misaligned); end
        tick();
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misaligned); end
    endtask

    task automatic test_kill_x0();
        set_ex(32'h1000, 32'h1111_2222, 3'b010, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        kill = 1'b1;
        #1;
        checks++; if (dcache_we !== 4'b0000) begin errors++; $display("FAIL kill_we: got %b expected 0000", dcache_we); end
        tick();
        kill = 1'b0;
        set_ex(32'h5, 32'h0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        #1;
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL kill_wb_we: got %b expected 0", wb_we); end
        tick();
        set_ex(32'h200, 32'h0, 3'b000, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h100);
        #1;
        checks++; if (wb_we !== 1'b0 || wb_data !== 32'h5) begin errors++; $display("FAIL x0_write: got we=%b data=%h expected we=0 data=00000005", wb_we, wb_data); end
        tick();
        set_ex(32'h0, 32'h0, 3'b000, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'hFFFF_FFFC);
        #1;
        checks++; if (wb_data !== 32'h104 || wb_we !== 1'b1 || wb_rd !== 5'd1) begin errors++; $display("FAIL jal_link: got data=%h we=%b rd=%0d expected 00000104 1 1", wb_data, wb_we, wb_rd); end
        tick();
        bubble();
        #1;
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL pc4_wrap: got %h expected 0", wb_data); end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] dv [3] = '{32'h0000_1234, 32'h0000_8000, 32'hABCD_7FFF};
        logic [31:0] ev [3] = '{32'h0000_1234, 32'hFFFF_8000, 32'h0000_7FFF};
        set_ex(32'h4000, 32'h0, 3'b001, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0);
        tick();
        stall = 1'b1;
        set_ex(32'h55, 32'h0, 3'b000, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            dcache_dout = dv[i];
            #1;
            checks++; if (wb_data !== ev[i] || wb_rd !== 5'd7 || wb_we !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got data=%h rd=%0d we=%b expected %h 7 1", i, wb_data, wb_rd, wb_we, ev[i]); end
            tick();
        end
        stall = 1'b0;
        dcache_dout = 32'h0000_8001;
        #1;
        checks++; if (wb_data !== 32'hFFFF_8001 || wb_rd !== 5'd7) begin errors++; $display("FAIL stall_release: got data=%h rd=%0d expected ffff8001 7", wb_data, wb_rd); end
        tick();
        checks++; if (wb_data !== 32'h55 || wb_rd !== 5'd9) begin errors++; $display("FAIL stall_next: got data=%h rd=%0d expected 00000055 9", wb_data, wb_rd); end
        set_ex(32'h1, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
        tick();
        bubble();
        stall = 1'b1;
        tick();
        tick();
        checks++; if (csr !== 32'h0) begin errors++; $display("FAIL csr_stalled: got %h expected 0", csr); end
        stall = 1'b0;
        tick();
        checks++; if (csr !== 32'h1) begin errors++; $display("FAIL csr_commit: got %h expected 1", csr); end
    endtask

    task automatic test_async_reset();
        set_ex(32'h77, 32'h0, 3'b000, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        tick();
        bubble();
        checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL pre_reset_we: got %b expected 1", wb_we); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (csr !== 32'h0) begin errors++; $display("FAIL async_csr: got %h expected 0", csr); end
        checks++; if (wb_we !== 1'b0 || wb_data !== 32'h0) begin errors++; $display("FAIL async_wb: got we=%b data=%h expected 0 0", wb_we, wb_data); end
        #4;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        kill = 1'b0;
        dcache_dout = 32'h0;
        bubble();
        #12;
        test_reset();
        reset = 1'b1;
        tick();
        test_store();
        test_load();
        test_misaligned();
        test_kill_x0();
        test_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
